kpn_fifo_scheduler: RTL

Controller that shares one KPN channel FIFO between `N_REQ` producer processes and one consumer process. It arbitrates producers round-robin and interleaves reads and writes fairly. It tracks occupancy itself, since the FIFO exposes no full/empty flags, and produces the FIFO's `wr`/`rd`/`entry_1` inputs. Every FIFO command is a single-cycle pulse followed by at least one low cycle, because the FIFO updates its pointers on changes of the command level.

---
 rtl/kpn_pkg.sv | 22 ++
 rtl/kpn_rr_arbiter.sv | 33 +++
 rtl/kpn_fifo_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kpn_pkg.sv
// Shared types and defaults for the KPN channel FIFO and its scheduler.
package kpn_pkg;

  localparam int DEF_BITS_NUMBER   = 16;
  localparam int DEF_FIFO_ELEMENTS = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMD  = 1'b1
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Width of a pointer that indexes n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kpn_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping around; the pointer register itself lives in the caller.
module kpn_rr_arbiter
  import kpn_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [PTR_W:0] pos;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(N_REQ)) begin
        pos = pos - (PTR_W+1)'(N_REQ);
      end
      if (!valid && req[pos[PTR_W-1:0]]) begin
        valid                = 1'b1;
        pick[pos[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kpn_fifo_scheduler.sv
// Shares one flagless KPN channel FIFO between N_REQ producers and one consumer,
// tracking occupancy locally and issuing single-cycle, non-consecutive commands.
module kpn_fifo_scheduler
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER   = DEF_BITS_NUMBER,
  parameter int FIFO_ELEMENTS = DEF_FIFO_ELEMENTS,
  parameter int N_REQ         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*BITS_NUMBER-1:0] wr_data,
  output logic [N_REQ-1:0]             grant,
  input  logic                         rd_req,
  output logic                         rd_valid,
  output logic [BITS_NUMBER-1:0]       rd_data,
  output logic                         fifo_wr,
  output logic                         fifo_rd,
  output logic [BITS_NUMBER-1:0]       fifo_data,
  input  logic [BITS_NUMBER-1:0]       fifo_q,
  output logic [FIFO_ELEMENTS:0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = ptr_width(N_REQ);
  localparam int CNT_W = FIFO_ELEMENTS + 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << FIFO_ELEMENTS;

  state_e                 state_q, state_d;
  op_e                    last_op_q, last_op_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic                   fifo_wr_q, fifo_wr_d;
  logic                   fifo_rd_q, fifo_rd_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [BITS_NUMBER-1:0] fifo_data_q, fifo_data_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0]       arb_pick;
  logic                   arb_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [BITS_NUMBER-1:0] pick_data;
  logic                   wr_elig;
  logic                   rd_elig;
  logic                   do_wr;
  logic                   do_rd;

  kpn_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (arb_pick),
    .valid  (arb_valid)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_pick[i]) begin
        pick_idx  = PTR_W'(i);
        pick_data = wr_data[i*BITS_NUMBER +: BITS_NUMBER];
      end
    end
  end

  assign next_ptr = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);

  assign full    = (count_q == CAPACITY);
  assign empty   = (count_q == '0);
  assign wr_elig = arb_valid & ~full;
  assign rd_elig = rd_req & ~empty;
  // Under contention, alternate against the last executed op.
  assign do_wr   = wr_elig & (~rd_elig | (last_op_q == OP_READ));
  assign do_rd   = rd_elig & ~do_wr;

  always_comb begin
    state_d     = state_q;
    last_op_d   = last_op_q;
    grant_d     = '0;
    fifo_wr_d   = 1'b0;
    fifo_rd_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    rd_valid_d  = fifo_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (do_wr) begin
          state_d     = ST_CMD;
          last_op_d   = OP_WRITE;
          grant_d     = arb_pick;
          fifo_wr_d   = 1'b1;
          fifo_data_d = pick_data;
          rr_ptr_d    = next_ptr;
        end else if (do_rd) begin
          state_d   = ST_CMD;
          last_op_d = OP_READ;
          fifo_rd_d = 1'b1;
        end
      end
      ST_CMD: begin
        // Commands return low for one cycle; occupancy follows the command just issued.
        state_d = ST_IDLE;
        if (fifo_wr_q && !full) begin
          count_d = count_q + CNT_W'(1);
        end else if (fifo_rd_q && !empty) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_op_q   <= OP_READ;
      grant_q     <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_rd_q   <= 1'b0;
      fifo_data_q <= '0;
      rd_valid_q  <= 1'b0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_op_q   <= last_op_d;
      grant_q     <= grant_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      rd_valid_q  <= rd_valid_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant     = grant_q;
  assign fifo_wr   = fifo_wr_q;
  assign fifo_rd   = fifo_rd_q;
  assign fifo_data = fifo_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = fifo_q;
  assign count     = count_q;

endmodule
